// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter shared definitions.
// State encodings and width helpers for the write-port arbiter.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin pick for fifo_wr_arbiter.
// Searches from last owner + 1 upward with wrap.
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             any_o
);

    logic             found;
    logic [IDX_W-1:0] idx;

    // first requester after last_i, the previous owner checked last
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        any_o   = |req_i;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IDX_W'((int'(last_i) + k) % N_REQ);
            if (!found && req_i[idx]) begin
                grant_o = idx;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port.
// Bounded bursts per owner; fifo_full holds the owner.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WORD_SIZE = 8,
    parameter int MAX_BURST = 4,
    localparam int IDX_W    = idx_w(N_REQ),
    localparam int CNT_W    = cnt_w(MAX_BURST)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WORD_SIZE-1:0] req_data,
    input  logic                       fifo_full,
    output logic [N_REQ-1:0]           ack,
    output logic                       fifo_wr,
    output logic [WORD_SIZE-1:0]       fifo_w_data,
    output logic                       owner_valid,
    output logic [IDX_W-1:0]           owner_id,
    output logic                       stall
);

    arb_state_e       state_q;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] last_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [IDX_W-1:0] pick;
    logic             any_req;
    logic             in_burst;
    logic             own_req;
    logic             last_beat;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (req),
        .last_i  (last_q),
        .grant_o (pick),
        .any_o   (any_req)
    );

    // port drive; reset masks everything so no write lands in a reset cycle
    always_comb begin
        in_burst    = (state_q == ARB_BURST) && !reset;
        own_req     = req[owner_q];
        fifo_wr     = in_burst && own_req && !fifo_full;
        stall       = in_burst && own_req && fifo_full;
        ack         = fifo_wr ? (N_REQ'(1) << owner_q) : '0;
        fifo_w_data = in_burst
                    ? req_data[int'(owner_q)*WORD_SIZE +: WORD_SIZE]
                    : '0;
        owner_valid = in_burst;
        owner_id    = reset ? '0 : owner_q;
        cnt_d       = cnt_q + CNT_W'(1);
        last_beat   = (cnt_q == CNT_W'(MAX_BURST - 1));
    end

    // arbitration FSM: one-cycle pick in IDLE, bounded burst in BURST
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (any_req) begin
                        owner_q <= pick;
                        cnt_q   <= '0;
                        state_q <= ARB_BURST;
                    end
                end
                ARB_BURST: begin
                    if (fifo_wr) begin
                        cnt_q <= cnt_d;
                        if (last_beat) begin
                            last_q  <= owner_q;
                            state_q <= ARB_IDLE;
                        end
                    end else if (!own_req) begin
                        last_q  <= owner_q;
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares one write port of fifo_parametrized among N_REQ requesters.
- Each requester presents a word and a request. The arbiter grants one owner at a time for a bounded burst of up to MAX_BURST words.
- It drives fifo wr/w_data and applies the FIFO's full flag as backpressure.
- Sits between producer blocks and the FIFO write side. The FIFO read side is untouched.

Parameters:
N_REQ, 4, number of requesters (>= 2)
WORD_SIZE, 8, data width; must match the FIFO's WORD_SIZE
MAX_BURST, 4, max words one owner writes per grant (>= 1)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
req  input  N_REQ  per-requester request; requester holds data stable while req=1
req_data  input  N_REQ*WORD_SIZE  flattened words; requester i uses bits [i*WORD_SIZE +: WORD_SIZE]
fifo_full  input  1  full flag from the FIFO
ack  output  N_REQ  one-hot; ack[i]=1 means the word from i is written at this clock edge
fifo_wr  output  1  to FIFO wr
fifo_w_data  output  WORD_SIZE  to FIFO w_data
owner_valid  output  1  arbiter in BURST state
owner_id  output  IDX_W  current owner index; IDX_W = $clog2(N_REQ)
stall  output  1  owner requesting but fifo_full blocks the write

Behaviour:
Registered state: state (IDLE/BURST), owner, last_owner, burst_cnt ($clog2(MAX_BURST+1) bits).

Reset (synchronous, reset=1 at the edge):
- state=IDLE, owner=0, last_owner=N_REQ-1 so requester 0 has first priority, burst_cnt=0.
- All outputs 0.
- Reset mid-burst aborts the burst. No write is issued in the reset cycle.

Outputs (combinational from registered state and inputs):
- fifo_wr = (state==BURST) & req[owner] & ~fifo_full
- ack = fifo_wr << owner
- fifo_w_data = req_data slice[owner] in BURST, else 0
- stall = (state==BURST) & req[owner] & fifo_full
- owner_valid = (state==BURST); owner_id = owner

IDLE state:
- If |req: owner <= first i with req[i]=1, searching (last_owner+1) mod N_REQ upward with wrap. Then state <= BURST, burst_cnt <= 0.
- Else remain in IDLE.
- Arbitration costs exactly one cycle; the first write comes one cycle after req is seen in IDLE.

BURST state:
- fifo_wr=1: burst_cnt increments. If burst_cnt == MAX_BURST-1, release: last_owner <= owner, state <= IDLE.
- req[owner]=0: release immediately, with no write that cycle.
- fifo_full with req[owner]=1: hold. No write, burst_cnt unchanged, stall=1. Ownership is never revoked while full.
- Requests from non-owners are ignored until release.

Boundaries:
- Writes are never issued while fifo_full=1. This avoids the FIFO's simultaneous rd/wr-when-full pointer case.
- The round-robin search wraps at N_REQ-1 → 0.
- A requester that re-asserts immediately after release loses priority to any other pending requester.

Decomposition:
- Shared package/include: ARB_IDLE=1'b0, ARB_BURST=1'b1 state encodings, and the IDX_W/CNT_W width derivations.
- One sub-module, rr_pick: combinational. Inputs are req[N_REQ] and last_owner. Outputs are the grant index and any_req.

Test Plan:
Setup for all scenarios: N_REQ=4, WORD_SIZE=8, MAX_BURST=4, connected to fifo_parametrized with MEM_SIZE=8.

1. Reset 2 cycles, then req=4'b0001 with data0=8'h11 held for 1 write:
   - All outputs are 0 during reset.
   - Cycle 1: owner_valid=1, owner_id=0.
   - Cycle 2: fifo_wr=1, ack=4'b0001, fifo_w_data=8'h11.
   - Then req drops → IDLE.
2. req=4'b1111 constant, FIFO drained every cycle (rd=1):
   - Bursts of 4 acks each, order 0,1,2,3,0.
   - One idle arbitration cycle between bursts, giving 16 writes in 20 cycles.
   - FIFO read sequence matches the grant order.
3. FIFO pre-filled with 8 words, req=4'b0100:
   - owner_id=2, stall=1, fifo_wr=0, ack=0, for as many cycles as full persists.
   - After one read pulse, full clears. The next cycle gives fifo_wr=1 and ack=4'b0100.
   - burst_cnt continues from its held value.
4. Owner 1 drops req after 2 writes while req[3] is pending:
   - Next cycle state=IDLE, then owner_id=3.
   - Total writes for owner 1 = 2.
5. Assert reset while owner 2 is at burst_cnt=2 with req=4'b0101:
   - Post-reset there are no writes in the reset cycle.
   - Next arbitration picks owner 0, since last_owner=3.
6. Owner 1 completes a burst with req=4'b1010 still asserted:
   - Next pick is 3, not 1.
   - The following burst goes back to 1.
